// File: rtl/complex_multiplier_arbiter.sv
// Round-robin sharing of one complex multiplier among NUM_CH AXI-Stream requesters,
// with credit-guarded per-channel result FIFOs. Define CMUL_ARB_STATS_EN for grant counters.
module complex_multiplier_arbiter #(
   parameter int  NUM_CH            = 4,
   parameter int  OPERAND_WIDTH_A   = 16,
   parameter int  OPERAND_WIDTH_B   = 16,
   parameter int  OPERAND_WIDTH_OUT = 32,
   parameter int  LATENCY           = 6,
   parameter int  CREDITS           = 8,
   localparam int AXIS_A            = ((2*OPERAND_WIDTH_A+15)/16)*16,
   localparam int AXIS_B            = ((2*OPERAND_WIDTH_B+15)/16)*16,
   localparam int AXIS_OUT          = ((2*OPERAND_WIDTH_OUT+15)/16)*16
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_CH*AXIS_A-1:0]     s_axis_a_tdata,
   input  logic [NUM_CH*AXIS_B-1:0]     s_axis_b_tdata,
   input  logic [NUM_CH-1:0]            s_axis_tvalid,
   output logic [NUM_CH-1:0]            s_axis_tready,
   output logic [AXIS_A-1:0]            m_axis_a_tdata,
   output logic [AXIS_B-1:0]            m_axis_b_tdata,
   output logic                         m_axis_tvalid,
   input  logic [AXIS_OUT-1:0]          s_axis_dout_tdata,
   input  logic                         s_axis_dout_tvalid,
   output logic [NUM_CH*AXIS_OUT-1:0]   m_axis_ch_tdata,
   output logic [NUM_CH-1:0]            m_axis_ch_tvalid,
   input  logic [NUM_CH-1:0]            m_axis_ch_tready,
   output logic                         tag_error,
   output logic [NUM_CH*32-1:0]         stat_grant_cnt
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(CREDITS);
   localparam int CRD_W = PTR_W + 1;

   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_ch;
   logic [CH_W-1:0]   cand [NUM_CH];

   logic [AXIS_A-1:0] m_a_q;
   logic [AXIS_B-1:0] m_b_q;
   logic              m_vld_q;
   logic [LATENCY:0]  tag_vld_q;
   logic [CH_W-1:0]   tag_ch_q [LATENCY+1];
   logic              tag_error_q;
   logic              ret_wr;

   // cand[gi] is the channel searched gi-th, starting from the round-robin pointer
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      logic [CH_W:0] sum;
      assign sum      = {1'b0, rr_ptr_q} + (CH_W+1)'(gi);
      assign cand[gi] = (sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum - (CH_W+1)'(NUM_CH))
                                                   : sum[CH_W-1:0];
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      for (int off = 0; off < NUM_CH; off++) begin
         if (!grant_vld && eligible[cand[off]]) begin
            grant_vld = 1'b1;
            grant_ch  = cand[off];
         end
      end
   end

   assign rr_ptr_d = !grant_vld                        ? rr_ptr_q :
                     (grant_ch == CH_W'(NUM_CH - 1))   ? '0       : grant_ch + 1'b1;

   // Stage 0 of the tag line lines up with the operand register; the tail meets the product
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr_q    <= '0;
         m_a_q       <= '0;
         m_b_q       <= '0;
         m_vld_q     <= 1'b0;
         tag_vld_q   <= '0;
         tag_error_q <= 1'b0;
         for (int s = 0; s <= LATENCY; s++) tag_ch_q[s] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         m_vld_q  <= grant_vld;
         if (grant_vld) begin
            m_a_q <= s_axis_a_tdata[grant_ch*AXIS_A +: AXIS_A];
            m_b_q <= s_axis_b_tdata[grant_ch*AXIS_B +: AXIS_B];
         end
         tag_vld_q   <= {tag_vld_q[LATENCY-1:0], grant_vld};
         tag_ch_q[0] <= grant_ch;
         for (int s = 1; s <= LATENCY; s++) tag_ch_q[s] <= tag_ch_q[s-1];
         tag_error_q <= tag_error_q | (tag_vld_q[LATENCY] ^ s_axis_dout_tvalid);
      end
   end

   assign ret_wr         = tag_vld_q[LATENCY] & s_axis_dout_tvalid;
   assign s_axis_tready  = grant;
   assign m_axis_a_tdata = m_a_q;
   assign m_axis_b_tdata = m_b_q;
   assign m_axis_tvalid  = m_vld_q;
   assign tag_error      = tag_error_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CRD_W-1:0]    credit_q, credit_d;
      logic [CRD_W-1:0]    cnt_q, cnt_d;
      logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
      logic [AXIS_OUT-1:0] mem_q [CREDITS];
      logic [AXIS_OUT-1:0] out_data_q;
      logic                out_vld_q;
      logic                wr_en, load, pop;

      assign eligible[gi] = aresetn & s_axis_tvalid[gi] & (credit_q != '0);
      assign grant[gi]    = grant_vld & (grant_ch == CH_W'(gi));
      assign wr_en        = ret_wr & (tag_ch_q[LATENCY] == CH_W'(gi));
      assign pop          = out_vld_q & m_axis_ch_tready[gi];
      assign load         = (cnt_q != '0) & (!out_vld_q | pop);

      always_comb begin
         credit_d = credit_q;
         case ({grant[gi], pop})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
         endcase
      end

      always_comb begin
         cnt_d = cnt_q;
         case ({wr_en, load})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge aclk) begin
         if (wr_en) mem_q[wr_ptr_q] <= s_axis_dout_tdata;
      end

      // Credits bound mem plus output register to CREDITS entries, so mem never overflows
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            credit_q   <= CRD_W'(CREDITS);
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
         end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) begin
               rd_ptr_q   <= rd_ptr_q + 1'b1;
               out_vld_q  <= 1'b1;
               out_data_q <= mem_q[rd_ptr_q];
            end else if (pop) begin
               out_vld_q <= 1'b0;
            end
         end
      end

      assign m_axis_ch_tvalid[gi]                       = out_vld_q;
      assign m_axis_ch_tdata[gi*AXIS_OUT +: AXIS_OUT]   = out_data_q;

`ifdef CMUL_ARB_STATS_EN
      logic [31:0] stat_q;
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn)       stat_q <= '0;
         else if (grant[gi]) stat_q <= stat_q + 32'd1;
      end
      assign stat_grant_cnt[gi*32 +: 32] = stat_q;
`else
      assign stat_grant_cnt[gi*32 +: 32] = 32'd0;
`endif
   end

endmodule
